// File: rtl/jt5205_fifo_if.sv
// Nibble push channel of the jt5205 FIFO decoder: valid/ready handshake.
interface jt5205_fifo_if;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/jt5205_fifo.sv
// jt5205_fifo: OKI/MSM5205-style ADPCM decoder fed from a nibble FIFO,
// with a cen-driven sample-rate prescaler and underrun reporting.
module jt5205_fifo #(
   parameter int AW = 4,
   parameter int OW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic [1:0]           sel,
   input  logic                 flush,
   jt5205_fifo_if.slave         in_if,
   output logic [AW:0]          level,
   output logic signed [OW-1:0] sound,
   output logic                 sample,
   output logic                 irq,
   output logic                 udf
);

   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [10:0] STEP_TAB [49] = '{
      16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80,
      88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337,
      371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282,
      1411, 1552};

   logic [3:0]          mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [6:0]          cnt, cnt_max;
   logic [1:0]          sel_q;
   logic [3:0]          nibble;
   logic                pend;
   logic signed [11:0]  acc, acc_next;
   logic [5:0]          idx, idx_next;
   logic signed [OW-1:0] sound_next;
   logic                tick, push, pop;

   assign in_if.din_ready = (level < FULL);
   assign push = in_if.din_valid & in_if.din_ready & ~flush;
   assign tick = cen & (sel != 2'd3) & (sel == sel_q) & (cnt == cnt_max) & ~flush;
   assign pop  = tick & (level != '0);

   // Prescaler terminal count for the selected sample rate
   always_comb begin
      cnt_max = '0;
      case (sel)
         2'd0:    cnt_max = 7'd95;
         2'd1:    cnt_max = 7'd63;
         2'd2:    cnt_max = 7'd47;
         default: cnt_max = '0;
      endcase
   end

   // Prescaler: count cen pulses, restart on flush, stop or any rate change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         sel_q <= '0;
      end else begin
         sel_q <= sel;
         if (flush || sel != sel_q || sel == 2'd3)
            cnt <= '0;
         else if (cen)
            cnt <= (cnt == cnt_max) ? '0 : cnt + 7'd1;
      end
   end

   // FIFO storage, written on accepted pushes
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_if.din;
   end

   // FIFO pointers/occupancy and tick handling (pop or underrun)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         nibble <= '0;
         irq    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         irq <= 1'b0;
         udf <= 1'b0;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (tick) begin
               irq <= 1'b1;
               if (level == '0) udf <= 1'b1;
            end
            if (pop) begin
               nibble <= mem[rd_ptr];
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
         end
      end
   end

   // ADPCM decode of the held nibble against current acc/idx
   always_comb begin
      logic [10:0]        step;
      logic [11:0]        diff;
      logic signed [13:0] sum;   // wide enough for max |acc| + max diff
      logic signed [7:0]  delta;
      logic signed [7:0]  isum;
      step = STEP_TAB[idx];
      diff = {4'd0, step[10:3]};
      if (nibble[2]) diff = diff + {1'b0, step};
      if (nibble[1]) diff = diff + {2'b0, step[10:1]};
      if (nibble[0]) diff = diff + {3'b0, step[10:2]};
      sum = nibble[3] ? ({{2{acc[11]}}, acc} - $signed({2'b0, diff}))
                      : ({{2{acc[11]}}, acc} + $signed({2'b0, diff}));
      if (sum > 14'sd2047)       acc_next = 12'sd2047;
      else if (sum < -14'sd2048) acc_next = -12'sd2048;
      else                       acc_next = sum[11:0];
      case (nibble[2:0])
         3'd4:    delta = 8'sd2;
         3'd5:    delta = 8'sd4;
         3'd6:    delta = 8'sd6;
         3'd7:    delta = 8'sd8;
         default: delta = -8'sd1;
      endcase
      isum = $signed({2'b0, idx}) + delta;
      if (isum < 8'sd0)       idx_next = '0;
      else if (isum > 8'sd48) idx_next = 6'd48;
      else                    idx_next = isum[5:0];
      sound_next = OW'(acc_next);
      sound_next = sound_next <<< (OW-12);
   end

   // Decode stage: one clk after a successful pop, publish the new sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= 1'b0;
         acc    <= '0;
         idx    <= '0;
         sound  <= '0;
         sample <= 1'b0;
      end else begin
         sample <= 1'b0;
         if (flush) begin
            pend  <= 1'b0;
            acc   <= '0;
            idx   <= '0;
            sound <= '0;
         end else begin
            pend <= pop;
            if (pend) begin
               acc    <= acc_next;
               idx    <= idx_next;
               sound  <= sound_next;
               sample <= 1'b1;
            end
         end
      end
   end

endmodule
